// File: rtl/lsu_mem_master_if.sv
// Signal bundle between the datapath, lsu_mem_master and the data memory.
// master: the load/store unit side; slave: the requester/memory environment side.
interface lsu_mem_master_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  mem_cs;
    logic                  mem_wr_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (
        input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_cs, mem_wr_rd, mem_addr, mem_din
    );

    modport slave (
        output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_cs, mem_wr_rd, mem_addr, mem_din
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the word-addressed synchronous-read data memory.
// Define LSU_ALIGN_CHECK_EN to trap misaligned half/word requests with rsp_err.
module lsu_mem_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RD_LATENCY = 1
) (
    input logic              clk,
    input logic              rst_n,
    lsu_mem_master_if.master bus
);
    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StMerge,
        StWr,
`ifdef LSU_ALIGN_CHECK_EN
        StErr,
`endif
        StResp
    } stateT;

    stateT                 stateQ, stateD;
    logic [2:0]            cntQ;
    logic                  wrQ;
    logic                  signedQ;
    logic [1:0]            sizeQ;
    logic [1:0]            offQ;
    logic [ADDR_WIDTH-1:0] wordAddrQ;
    logic [DATA_WIDTH-1:0] wdataQ;
    logic [DATA_WIDTH-1:0] holdQ;
    logic [DATA_WIDTH-1:0] rdataQ;
    logic [DATA_WIDTH-1:0] loadData;
    logic [DATA_WIDTH-1:0] mergedWord;
    logic [7:0]            byteSel;
    logic [15:0]           halfSel;
    logic [1:0]            reqOff;
    logic                  reqHalf;
    logic                  reqWord;
    logic                  accept;
    logic                  lastWait;
    logic                  unusedAddr;

    assign reqHalf  = (bus.req_size == 2'b01);
    assign reqWord  = bus.req_size[1];
    // Low address bits that would misalign a half/word access are dropped here.
    assign reqOff   = reqWord ? 2'b00 :
                      reqHalf ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0];
    assign accept   = bus.req_valid && (stateQ == StIdle);
    assign lastWait = (stateQ == StWait) && (cntQ == 3'd0);
    assign unusedAddr = ^bus.req_addr[31:ADDR_WIDTH+2];

`ifdef LSU_ALIGN_CHECK_EN
    logic misaligned;
    logic errQ;
    assign misaligned = (reqHalf && bus.req_addr[0]) || (reqWord && (bus.req_addr[1:0] != 2'b00));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (bus.req_valid) begin
`ifdef LSU_ALIGN_CHECK_EN
                    if (misaligned) stateD = StErr;
                    else
`endif
                    if (bus.req_wr && reqWord) stateD = StWr;
                    else                       stateD = StRd;
                end
            end
            StRd:    stateD = StWait;
            StWait:  if (lastWait) stateD = wrQ ? StMerge : StResp;
            StMerge: stateD = StWr;
            StWr:    stateD = StResp;
`ifdef LSU_ALIGN_CHECK_EN
            StErr:   stateD = StResp;
`endif
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // Counts the remaining read-latency cycles spent in StWait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntQ <= 3'd0;
        end else if (stateQ == StRd) begin
            cntQ <= 3'(RD_LATENCY - 1);
        end else if ((stateQ == StWait) && (cntQ != 3'd0)) begin
            cntQ <= cntQ - 3'd1;
        end
    end

    always_comb begin
        byteSel = bus.mem_dout[7:0];
        case (offQ)
            2'd1:    byteSel = bus.mem_dout[15:8];
            2'd2:    byteSel = bus.mem_dout[23:16];
            2'd3:    byteSel = bus.mem_dout[31:24];
            default: byteSel = bus.mem_dout[7:0];
        endcase
        halfSel = offQ[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
        if (sizeQ == 2'b00) begin
            loadData = {{24{signedQ & byteSel[7]}}, byteSel};
        end else if (sizeQ == 2'b01) begin
            loadData = {{16{signedQ & halfSel[15]}}, halfSel};
        end else begin
            loadData = bus.mem_dout;
        end
    end

    always_comb begin
        mergedWord = holdQ;
        if (sizeQ == 2'b00) begin
            case (offQ)
                2'd1:    mergedWord[15:8]  = wdataQ[7:0];
                2'd2:    mergedWord[23:16] = wdataQ[7:0];
                2'd3:    mergedWord[31:24] = wdataQ[7:0];
                default: mergedWord[7:0]   = wdataQ[7:0];
            endcase
        end else if (offQ[1]) begin
            mergedWord[31:16] = wdataQ[15:0];
        end else begin
            mergedWord[15:0] = wdataQ[15:0];
        end
    end

    // holdQ carries the word to be written: req_wdata for word stores, merged RMW data otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrQ       <= 1'b0;
            signedQ   <= 1'b0;
            sizeQ     <= 2'b00;
            offQ      <= 2'b00;
            wordAddrQ <= '0;
            wdataQ    <= '0;
            holdQ     <= '0;
            rdataQ    <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            errQ      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                wrQ       <= bus.req_wr;
                signedQ   <= bus.req_signed;
                sizeQ     <= bus.req_size;
                offQ      <= reqOff;
                wordAddrQ <= bus.req_addr[ADDR_WIDTH+1:2];
                wdataQ    <= bus.req_wdata;
                holdQ     <= bus.req_wdata;
                rdataQ    <= '0;
`ifdef LSU_ALIGN_CHECK_EN
                errQ      <= misaligned;
`endif
            end
            if (lastWait) begin
                holdQ <= bus.mem_dout;
                if (!wrQ) rdataQ <= loadData;
            end
            if (stateQ == StMerge) holdQ <= mergedWord;
        end
    end

    assign bus.req_ready = (stateQ == StIdle) && rst_n;
    assign bus.mem_cs    = (stateQ == StRd) || (stateQ == StWr);
    assign bus.mem_wr_rd = (stateQ != StWr);
    assign bus.mem_addr  = bus.mem_cs ? wordAddrQ : '0;
    assign bus.mem_din   = (stateQ == StWr) ? holdQ : '0;
    assign bus.rsp_valid = (stateQ == StResp);
    assign bus.rsp_rdata = bus.rsp_valid ? rdataQ : '0;
`ifdef LSU_ALIGN_CHECK_EN
    assign bus.rsp_err   = bus.rsp_valid && errQ;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed scenarios plus randomized
// traffic compared against a byte-array reference memory.
module tb_lsu_mem_master;
    localparam int unsigned RL = 1;
`ifdef LSU_ALIGN_CHECK_EN
    localparam bit AlignChk = 1'b1;
`else
    localparam bit AlignChk = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    lsu_mem_master_if bus ();

    lsu_mem_master #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(10),
        .RD_LATENCY(RL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] memArr [1024];
    logic        memReady = 1'b0;
    logic [31:0] rdPipe [RL];
    logic [7:0]  refMem [4096];
    int          nChecks = 0;
    int          nFails = 0;
    int          wrCount = 0;
    int          rdCount = 0;
    int          rspCount = 0;
    logic [9:0]  lastWrAddr = '0;
    logic [9:0]  lastRdAddr = '0;
    logic [31:0] lastWrData = '0;

    function automatic logic [31:0] initWord(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Environment memory: synchronous read, RL cycles from the sampling edge.
    always @(posedge clk) begin
        if (!memReady) begin
            for (int i = 0; i < 1024; i++) memArr[i] <= initWord(i);
            memReady <= 1'b1;
        end else if (bus.mem_cs && !bus.mem_wr_rd) begin
            memArr[bus.mem_addr] <= bus.mem_din;
        end
        rdPipe[0] <= (bus.mem_cs && bus.mem_wr_rd) ? memArr[bus.mem_addr] : 32'hBAD0_BAD0;
        for (int i = 1; i < int'(RL); i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign bus.mem_dout = rdPipe[RL-1];

    always @(negedge clk) begin
        if (bus.mem_cs && !bus.mem_wr_rd) begin
            wrCount    <= wrCount + 1;
            lastWrAddr <= bus.mem_addr;
            lastWrData <= bus.mem_din;
        end
        if (bus.mem_cs && bus.mem_wr_rd) begin
            rdCount    <= rdCount + 1;
            lastRdAddr <= bus.mem_addr;
        end
        if (bus.rsp_valid) rspCount <= rspCount + 1;
    end

    function automatic int sizeBytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] refLoad(input logic [1:0] size, input logic sgn,
                                            input logic [31:0] addr);
        int n;
        int a;
        longint unsigned v;
        n = sizeBytes(size);
        a = int'(addr % 32'd4096);
        a = a - (a % n);
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(refMem[a+i]) << (8 * i));
        if (sgn && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic void refStore(input logic [1:0] size, input logic [31:0] addr,
                                     input logic [31:0] wdata);
        int n;
        int a;
        n = sizeBytes(size);
        a = int'(addr % 32'd4096);
        a = a - (a % n);
        for (int i = 0; i < n; i++) refMem[a+i] = wdata[8*i +: 8];
    endfunction

    // Issues one request and waits for its response; lat is 999 if none arrives.
    task automatic doReq(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int dWr, output int dRd);
        int wr0;
        int rd0;
        int k;
        rdata = 'x;
        err   = 1'bx;
        lat   = 999;
        @(negedge clk);
        wr0 = wrCount;
        rd0 = rdCount;
        bus.req_wr = wr; bus.req_size = size; bus.req_signed = sgn;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
        k = 0;
        while (!bus.req_ready && k < 50) begin @(negedge clk); k++; end
        if (bus.req_ready) begin
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            k = 1;
            @(negedge clk);
            while (!bus.rsp_valid && k < 40) begin @(negedge clk); k++; end
            if (bus.rsp_valid) begin
                lat = k; rdata = bus.rsp_rdata; err = bus.rsp_err;
            end
        end
        bus.req_valid = 1'b0;
        dWr = wrCount - wr0;
        dRd = rdCount - rd0;
    endtask

    task automatic test_reset();
        int rsp0;
        int wr0;
        logic [31:0] rd;
        logic er;
        int lat, dw, dr;
        @(negedge clk);
        nChecks++; if (bus.req_ready !== 1'b0) begin nFails++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
        nChecks++; if (bus.rsp_valid !== 1'b0) begin nFails++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        nChecks++; if (bus.rsp_rdata !== 32'h0) begin nFails++; $display("FAIL rst_rdata: got %h want 0", bus.rsp_rdata); end
        nChecks++; if (bus.rsp_err !== 1'b0) begin nFails++; $display("FAIL rst_err: got %b want 0", bus.rsp_err); end
        nChecks++; if (bus.mem_cs !== 1'b0) begin nFails++; $display("FAIL rst_cs: got %b want 0", bus.mem_cs); end
        nChecks++; if (bus.mem_wr_rd !== 1'b1) begin nFails++; $display("FAIL rst_wr_rd: got %b want 1", bus.mem_wr_rd); end
        nChecks++; if (bus.mem_addr !== 10'h0) begin nFails++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
        nChecks++; if (bus.mem_din !== 32'h0) begin nFails++; $display("FAIL rst_din: got %h want 0", bus.mem_din); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nChecks++; if (bus.req_ready !== 1'b1) begin nFails++; $display("FAIL rel_ready: got %b want 1", bus.req_ready); end

        // Kill a load while it waits on read data.
        rsp0 = rspCount;
        bus.req_wr = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
        bus.req_addr = 32'h20; bus.req_wdata = '0; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        nChecks++; if (bus.mem_cs !== 1'b1) begin nFails++; $display("FAIL kill_rd_cs: got %b want 1", bus.mem_cs); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        nChecks++; if (bus.mem_cs !== 1'b0) begin nFails++; $display("FAIL kill_cs: got %b want 0", bus.mem_cs); end
        nChecks++; if (bus.rsp_valid !== 1'b0) begin nFails++; $display("FAIL kill_rsp: got %b want 0", bus.rsp_valid); end
        nChecks++; if (bus.req_ready !== 1'b0) begin nFails++; $display("FAIL kill_ready: got %b want 0", bus.req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nChecks++; if (bus.req_ready !== 1'b1) begin nFails++; $display("FAIL kill_rel_ready: got %b want 1", bus.req_ready); end
        repeat (10) @(negedge clk);
        nChecks++; if (rspCount !== rsp0) begin nFails++; $display("FAIL kill_no_rsp: got %0d want %0d", rspCount, rsp0); end

        // Kill a byte store during its merge cycle: the write must never happen.
        wr0 = wrCount;
        rsp0 = rspCount;
        bus.req_wr = 1'b1; bus.req_size = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr = 32'h21; bus.req_wdata = 32'h5C; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (RL + 1) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        nChecks++; if (bus.mem_cs !== 1'b0) begin nFails++; $display("FAIL kill_st_cs: got %b want 0", bus.mem_cs); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        nChecks++; if (wrCount !== wr0) begin nFails++; $display("FAIL kill_st_nowr: got %0d want %0d", wrCount, wr0); end
        nChecks++; if (rspCount !== rsp0) begin nFails++; $display("FAIL kill_st_norsp: got %0d want %0d", rspCount, rsp0); end
        doReq(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, rd, er, lat, dw, dr);
        nChecks++; if (rd !== refLoad(2'd0, 1'b0, 32'h21)) begin nFails++; $display("FAIL kill_st_mem: got %h want %h", rd, refLoad(2'd0, 1'b0, 32'h21)); end
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd;
        logic er;
        int lat, dw, dr;
        doReq(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat, dw, dr);
        refStore(2'd2, 32'h10, 32'hDEAD_BEEF);
        nChecks++; if (lat !== 2) begin nFails++; $display("FAIL ws_lat: got %0d want 2", lat); end
        nChecks++; if (dw !== 1 || dr !== 0) begin nFails++; $display("FAIL ws_access: got wr=%0d rd=%0d want wr=1 rd=0", dw, dr); end
        nChecks++; if (lastWrAddr !== 10'd4) begin nFails++; $display("FAIL ws_addr: got %0d want 4", lastWrAddr); end
        nChecks++; if (lastWrData !== 32'hDEAD_BEEF) begin nFails++; $display("FAIL ws_din: got %h want deadbeef", lastWrData); end
        nChecks++; if (rd !== 32'h0 || er !== 1'b0) begin nFails++; $display("FAIL ws_rsp: got %h/%b want 0/0", rd, er); end
        doReq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, dw, dr);
        nChecks++; if (rd !== 32'hDEAD_BEEF) begin nFails++; $display("FAIL wl_data: got %h want deadbeef", rd); end
        nChecks++; if (lat !== int'(RL) + 2) begin nFails++; $display("FAIL wl_lat: got %0d want %0d", lat, RL + 2); end
        nChecks++; if (dr !== 1 || lastRdAddr !== 10'd4) begin nFails++; $display("FAIL wl_rd: got n=%0d addr=%0d want 1/4", dr, lastRdAddr); end
    endtask

    task automatic test_byte_rmw();
        logic [31:0] rd;
        logic er;
        int lat, dw, dr;
        doReq(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, rd, er, lat, dw, dr);
        refStore(2'd2, 32'h10, 32'h1122_3344);
        doReq(1'b1, 2'd0, 1'b0, 32'h13, 32'hA5, rd, er, lat, dw, dr);
        refStore(2'd0, 32'h13, 32'hA5);
        nChecks++; if (lat !== int'(RL) + 4) begin nFails++; $display("FAIL rmw_lat: got %0d want %0d", lat, RL + 4); end
        nChecks++; if (dr !== 1 || lastRdAddr !== 10'd4) begin nFails++; $display("FAIL rmw_rd: got n=%0d addr=%0d want 1/4", dr, lastRdAddr); end
        nChecks++; if (dw !== 1 || lastWrAddr !== 10'd4) begin nFails++; $display("FAIL rmw_wr: got n=%0d addr=%0d want 1/4", dw, lastWrAddr); end
        nChecks++; if (lastWrData !== 32'hA522_3344) begin nFails++; $display("FAIL rmw_din: got %h want a5223344", lastWrData); end
        nChecks++; if (rd !== 32'h0 || er !== 1'b0) begin nFails++; $display("FAIL rmw_rsp: got %h/%b want 0/0", rd, er); end
    endtask

    task automatic test_extension();
        logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] ex  [4] = '{32'hFFFF_FFA5, 32'h0000_00A5, 32'hFFFF_A522, 32'h0000_3344};
        logic [31:0] rd;
        logic er;
        int lat, dw, dr;
        for (int i = 0; i < 4; i++) begin
            doReq(1'b0, sz[i], sg[i], ad[i], 32'h0, rd, er, lat, dw, dr);
            nChecks++; if (rd !== ex[i]) begin nFails++; $display("FAIL ext%0d: got %h want %h", i, rd, ex[i]); end
            nChecks++; if (lat !== int'(RL) + 2) begin nFails++; $display("FAIL ext%0d_lat: got %0d want %0d", i, lat, RL + 2); end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        logic er;
        int lat, dw, dr;
        doReq(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, rd, er, lat, dw, dr);
        nChecks++; if (rd !== (AlignChk ? 32'h0 : 32'hA522_3344)) begin nFails++; $display("FAIL mis_data: got %h", rd); end
        nChecks++; if (er !== AlignChk) begin nFails++; $display("FAIL mis_err: got %b want %b", er, AlignChk); end
        nChecks++; if (lat !== (AlignChk ? 2 : int'(RL) + 2)) begin nFails++; $display("FAIL mis_lat: got %0d", lat); end
        nChecks++; if (dr !== (AlignChk ? 0 : 1) || dw !== 0) begin nFails++; $display("FAIL mis_access: got rd=%0d wr=%0d", dr, dw); end
        doReq(1'b1, 2'd1, 1'b0, 32'h11, 32'h7788, rd, er, lat, dw, dr);
        if (!AlignChk) refStore(2'd1, 32'h11, 32'h7788);
        nChecks++; if (er !== AlignChk || dw !== (AlignChk ? 0 : 1)) begin nFails++; $display("FAIL mis_half_st: got err=%b wr=%0d", er, dw); end
        doReq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, dw, dr);
        nChecks++; if (rd !== (AlignChk ? 32'hA522_3344 : 32'hA522_7788)) begin nFails++; $display("FAIL mis_half_mem: got %h", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp1, exp2, got1, got2;
        logic readyAtResp, readyAfter;
        int k, busyReady, lat1, lat2;
        exp1 = refLoad(2'd2, 1'b0, 32'h10);
        exp2 = refLoad(2'd2, 1'b0, 32'h1000);
        @(negedge clk);
        bus.req_wr = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
        bus.req_addr = 32'h10; bus.req_wdata = '0; bus.req_valid = 1'b1;
        k = 0;
        while (!bus.req_ready && k < 50) begin @(negedge clk); k++; end
        @(posedge clk);
        #1 bus.req_addr = 32'h1000;
        busyReady = 0;
        k = 1;
        @(negedge clk);
        while (!bus.rsp_valid && k < 40) begin
            if (bus.req_ready) busyReady++;
            @(negedge clk);
            k++;
        end
        lat1 = bus.rsp_valid ? k : 999;
        got1 = bus.rsp_valid ? bus.rsp_rdata : 'x;
        readyAtResp = bus.req_ready;
        @(negedge clk);
        readyAfter = bus.req_ready;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        k = 1;
        @(negedge clk);
        while (!bus.rsp_valid && k < 40) begin @(negedge clk); k++; end
        lat2 = bus.rsp_valid ? k : 999;
        got2 = bus.rsp_valid ? bus.rsp_rdata : 'x;
        nChecks++; if (got1 !== exp1 || lat1 !== int'(RL) + 2) begin nFails++; $display("FAIL b2b_first: got %h lat %0d want %h lat %0d", got1, lat1, exp1, RL + 2); end
        nChecks++; if (busyReady !== 0 || readyAtResp !== 1'b0) begin nFails++; $display("FAIL b2b_busy_ready: got %0d/%b want 0/0", busyReady, readyAtResp); end
        nChecks++; if (readyAfter !== 1'b1) begin nFails++; $display("FAIL b2b_ready_after: got %b want 1", readyAfter); end
        nChecks++; if (got2 !== exp2 || lat2 !== int'(RL) + 2) begin nFails++; $display("FAIL b2b_second: got %h lat %0d want %h lat %0d", got2, lat2, exp2, RL + 2); end
        nChecks++; if (lastRdAddr !== 10'd0) begin nFails++; $display("FAIL wrap_addr: got %0d want 0", lastRdAddr); end
    endtask

    task automatic test_random();
        logic        wr, sgn, er, mis, trap;
        logic [1:0]  size;
        logic [31:0] addr, wdata, rd, expRd;
        int lat, dw, dr, n, expLat, expDw, expDr;
        for (int it = 0; it < 200; it++) begin
            wr    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            sgn   = 1'($urandom_range(0, 1));
            addr  = 32'($urandom_range(0, 47));
            if ($urandom_range(0, 3) == 0) addr = addr | ($urandom << 12);
            wdata = $urandom;
            n     = sizeBytes(size);
            mis   = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
            trap  = AlignChk && mis;
            expRd  = (wr || trap) ? 32'h0 : refLoad(size, sgn, addr);
            expLat = trap ? 2 : !wr ? int'(RL) + 2 : (n == 4) ? 2 : int'(RL) + 4;
            expDw  = (trap || !wr) ? 0 : 1;
            expDr  = (trap || (wr && n == 4)) ? 0 : 1;
            doReq(wr, size, sgn, addr, wdata, rd, er, lat, dw, dr);
            if (wr && !trap) refStore(size, addr, wdata);
            nChecks++; if (rd !== expRd) begin nFails++; $display("FAIL rnd%0d_data: got %h want %h", it, rd, expRd); end
            nChecks++; if (er !== trap) begin nFails++; $display("FAIL rnd%0d_err: got %b want %b", it, er, trap); end
            nChecks++; if (lat !== expLat) begin nFails++; $display("FAIL rnd%0d_lat: got %0d want %0d", it, lat, expLat); end
            nChecks++; if (dw !== expDw || dr !== expDr) begin nFails++; $display("FAIL rnd%0d_access: got wr=%0d rd=%0d want wr=%0d rd=%0d", it, dw, dr, expDw, expDr); end
            if (expDw == 1) begin
                nChecks++;
                if (lastWrAddr !== 10'((addr % 32'd4096) / 32'd4) ||
                    lastWrData !== refLoad(2'd2, 1'b0, addr & 32'hFFFF_FFFC)) begin
                    nFails++;
                    $display("FAIL rnd%0d_wr: got %0d:%h want %0d:%h", it, lastWrAddr, lastWrData,
                             (addr % 32'd4096) / 32'd4, refLoad(2'd2, 1'b0, addr & 32'hFFFF_FFFC));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            w = initWord(i);
            for (int b = 0; b < 4; b++) refMem[4*i+b] = w[8*b +: 8];
        end
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0;
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_extension();
        test_misaligned();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-addressed, synchronous-read data memory on behalf of the MIPS datapath.
- Accepts byte-addressed byte/half/word load and store requests through a valid/ready handshake.
- Issues memory cycles on the cs/WR_RD/ADDR/din bus, extracts and extends load data, and performs read-modify-write for sub-word stores.
- Returns a one-cycle response pulse per request.

Parameters:
DATA_WIDTH, 32, memory word width; fixed at 32 for lane logic.
ADDR_WIDTH, 10, memory word-address width.
RD_LATENCY, 1, cycles from the read-sampling edge to valid mem_dout; legal range 1..4.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted on an edge where valid&ready
req_wr  input  1  1=store, 0=load
req_size  input  2  00=byte, 01=half, 10=word, 11=treated as word
req_signed  input  1  sign-extend sub-word loads
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  load result; 0 for stores and errors
rsp_err  output  1  misaligned request, qualified by rsp_valid
mem_cs  output  1  memory chip select
mem_wr_rd  output  1  1=read, 0=write
mem_addr  output  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2]
mem_din  output  DATA_WIDTH  write data to memory
mem_dout  input  DATA_WIDTH  read data from memory

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE; req_ready=0 while rst_n=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_cs=0, mem_wr_rd=1, mem_addr=0, mem_din=0.
- Reset mid-operation: the access is abandoned, the bus deasserts at once, and no write is completed.
- States: IDLE, RD, WAIT, MERGE, WR, ERR, RESP.
- IDLE: req_ready=1. On accept, latch all req fields.
  - Next state ERR if misaligned, RD if load or sub-word store, WR if word store.
- RD (1 cycle): mem_cs=1, mem_wr_rd=1, mem_addr=latched word address.
- WAIT (RD_LATENCY cycles, counter-driven): mem_cs=0.
  - On the final edge, capture mem_dout into a holding register.
  - Next state RESP for a load, MERGE for a store.
- MERGE (1 cycle): replace the addressed lane(s) of the held word with req_wdata[7:0] or [15:0].
  - Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
- WR (1 cycle): mem_cs=1, mem_wr_rd=0, mem_addr, mem_din=merged word (or req_wdata for a word store).
- ERR (1 cycle): no memory access → RESP with rsp_err=1.
- RESP (1 cycle): rsp_valid=1 with registered rsp_rdata/rsp_err, then → IDLE.
- Load data: select the lane, then zero- or sign-extend per req_signed. Word loads ignore req_signed.
- Latency, counting edges after the accept edge E0 until rsp_valid rises:
  - word store: 2
  - load: RD_LATENCY+2
  - sub-word store: RD_LATENCY+4
  - error: 2
- Request and response rules:
  - req_ready=0 outside IDLE, so there is at most one outstanding request.
  - rsp_valid has no backpressure.
- Outside RD/WR: mem_cs=0, mem_wr_rd=1, mem_addr=0, mem_din=0.
- Address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo 4·2^ADDR_WIDTH bytes.

Optional Feature:
LSU_ALIGN_CHECK_EN:
- Defined: a half request with addr[0]=1, or a word request with addr[1:0]≠0, takes the ERR path with rsp_err=1 and no memory access.
- Undefined: ERR state is absent and rsp_err is tied 0.
  - Misaligned low address bits are forced to zero: addr[0] for half, addr[1:0] for word.
  - The access proceeds normally.

Test Plan:
- Reset: assert rst_n=0 during WAIT of a load → mem_cs=0, rsp_valid=0, req_ready=0 immediately; after release, req_ready=1 on the next cycle and no rsp is ever produced for the killed load.
- Word store then load: store 0x10 data 0xDEADBEEF → one cycle mem_cs=1, mem_wr_rd=0, mem_addr=4, mem_din=0xDEADBEEF, rsp_valid 2 edges after accept; load word 0x10 → rsp_rdata=0xDEADBEEF at RD_LATENCY+2 edges.
- Byte store RMW: memory word 4 holds 0x11223344; store byte 0x13 data 0xA5 → read at mem_addr=4, then write 0xA5223344; rsp_rdata=0.
- Extension: after the above, signed byte load 0x13 → 0xFFFFFFA5; unsigned → 0x000000A5; signed half 0x12 → 0xFFFFA522; unsigned half 0x10 → 0x00003344.
- Misaligned word load 0x12:
  - With LSU_ALIGN_CHECK_EN → rsp_err=1, rsp_rdata=0, rsp_valid 2 edges after accept, mem_cs never high.
  - Without it → reads mem_addr=4 and returns the full word.
- Back-to-back and wrap: req_valid held high with two loads → second accepted only on the edge after the first's RESP; load 0x1000 → mem_addr=0 (ADDR_WIDTH=10).
